// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller:
// FSM encoding, default register map and status bit layout.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_MASK_ADDR = 32'hF0000810;
    localparam logic [31:0] DEF_PEND_ADDR = 32'hF0000814;
    localparam logic [31:0] DEF_STAT_ADDR = 32'hF0000818;

    localparam int STAT_REQ_BIT = 0;
    localparam int STAT_SVC_BIT = 1;
    localparam int STAT_ID_LSB  = 4;
    localparam int STAT_RR_LSB  = 8;

endpackage

// File: rtl/interrupt_controller_rr_arbiter.sv
// Combinational round-robin picker: grants the eligible
// source closest to rrPtr going upward with wrap-around.
module rr_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [2:0]         rrPtr,
    output logic [2:0]         grantIdx,
    output logic               grantValid
);

    // Pick the eligible index with the smallest forward distance from rrPtr
    always_comb begin
        int w_best;
        int w_dist;
        grantIdx   = 3'd0;
        grantValid = 1'b0;
        w_best     = NUM_SRC;
        w_dist     = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i >= int'(rrPtr)) begin
                w_dist = i - int'(rrPtr);
            end else begin
                w_dist = i + NUM_SRC - int'(rrPtr);
            end
            if (eligible[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                grantIdx   = 3'(i);
                grantValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-captured pending bits,
// mask, round-robin selection and a REQ/SERVICE/EOI handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          BITS      = 32,
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] MASK_ADDR = DEF_MASK_ADDR,
    parameter logic [31:0] PEND_ADDR = DEF_PEND_ADDR,
    parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    output logic [BITS-1:0]    dataBusOut,
    input  logic [NUM_SRC-1:0] irq,
    output logic               intReq,
    output logic [2:0]         intId,
    input  logic               intAck
);

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_mask;
    logic [NUM_SRC-1:0]   r_irqPrev;
    logic [2:0]           r_rrPtr;
    logic [2:0]           r_intId;

    logic [NUM_SRC-1:0]   w_clear;
    logic [NUM_SRC-1:0]   w_pend_next;
    logic [2:0]           w_grantIdx;
    logic                 w_grantValid;
    logic                 w_wr_mask;
    logic                 w_wr_pend;
    logic                 w_wr_stat;
    logic                 w_latch_id;
    logic                 w_ack;
    logic                 w_eoi;
    logic [BITS-1:0]      w_status;
    logic [2:0]           w_rr_next;

    assign w_wr_mask = we && (memAddr == BITS'(MASK_ADDR));
    assign w_wr_pend = we && (memAddr == BITS'(PEND_ADDR));
    assign w_wr_stat = we && (memAddr == BITS'(STAT_ADDR));

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .eligible   (r_pending & r_mask),
        .rrPtr      (r_rrPtr),
        .grantIdx   (w_grantIdx),
        .grantValid (w_grantValid)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and the one-cycle control events it produces
    always_comb begin
        w_state_next = r_state;
        w_latch_id   = 1'b0;
        w_ack        = 1'b0;
        w_eoi        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grantValid) begin
                    w_latch_id   = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (intAck) begin
                    w_ack        = 1'b1;
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_wr_stat) begin
                    w_eoi        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pending update; a fresh rising edge beats any same-cycle clear
    always_comb begin
        w_clear = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clear[i] = (w_ack && (r_intId == 3'(i)))
                       || (w_wr_pend && dataBusIn[i]);
        end
        w_pend_next = (irq & ~r_irqPrev) | (r_pending & ~w_clear);
        w_rr_next = (r_intId == 3'(NUM_SRC - 1)) ? 3'd0 : r_intId + 3'd1;
    end

    // Datapath registers: edge history, pending, mask, id, pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqPrev <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_intId   <= 3'd0;
            r_rrPtr   <= 3'd0;
        end else begin
            r_irqPrev <= irq;
            r_pending <= w_pend_next;
            if (w_wr_mask) begin
                r_mask <= dataBusIn[NUM_SRC-1:0];
            end
            if (w_latch_id) begin
                r_intId <= w_grantIdx;
            end
            if (w_eoi) begin
                r_rrPtr <= w_rr_next;
            end
        end
    end

    // Read mux; status is assembled from live state
    always_comb begin
        w_status = '0;
        w_status[STAT_REQ_BIT] = (r_state == ST_REQ);
        w_status[STAT_SVC_BIT] = (r_state == ST_SERVICE);
        w_status[STAT_ID_LSB +: 3] = r_intId;
        w_status[STAT_RR_LSB +: 3] = r_rrPtr;
        dataBusOut = '0;
        if (re && !we) begin
            if (memAddr == BITS'(MASK_ADDR)) begin
                dataBusOut[NUM_SRC-1:0] = r_mask;
            end else if (memAddr == BITS'(PEND_ADDR)) begin
                dataBusOut[NUM_SRC-1:0] = r_pending;
            end else if (memAddr == BITS'(STAT_ADDR)) begin
                dataBusOut = w_status;
            end
        end
    end

    assign intReq = (r_state == ST_REQ);
    assign intId  = r_intId;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table,
// hand sequences and a randomized run against a model.
module tb_interrupt_controller;

    localparam int          BITS = 32;
    localparam int          NSRC = 4;
    localparam logic [31:0] A_MASK = 32'hF0000810;
    localparam logic [31:0] A_PEND = 32'hF0000814;
    localparam logic [31:0] A_STAT = 32'hF0000818;
    localparam logic [31:0] A_NONE = 32'hF000081C;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic            re;
    logic [31:0]     memAddr;
    logic [31:0]     dataBusIn;
    logic [31:0]     dataBusOut;
    logic [NSRC-1:0] irq;
    logic            intReq;
    logic [2:0]      intId;
    logic            intAck;

    always #5 clk = ~clk;

    interrupt_controller #(
        .BITS      (BITS),
        .NUM_SRC   (NSRC),
        .MASK_ADDR (A_MASK),
        .PEND_ADDR (A_PEND),
        .STAT_ADDR (A_STAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .irq        (irq),
        .intReq     (intReq),
        .intId      (intId),
        .intAck     (intAck)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 in service
    bit       m_valid = 1'b0;
    int       m_phase;
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev;
    int       m_id;
    int       m_rr;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  irqv;
        logic        ack;
        logic        e_req;
        logic [2:0]  e_id;
        logic [31:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic wr, logic rd,
                                logic [31:0] addr, logic [31:0] din,
                                logic [3:0] irqv, logic ack,
                                logic e_req, logic [2:0] e_id,
                                logic [31:0] e_dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd;
        v.addr = addr; v.din = din; v.irqv = irqv;
        v.ack = ack; v.e_req = e_req; v.e_id = e_id;
        v.e_dout = e_dout;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(logic rd, logic wr,
                                           logic [31:0] a);
        logic [31:0] s;
        s = 32'd0;
        if (rd && !wr) begin
            if (a == A_MASK) s = 32'(m_mask);
            else if (a == A_PEND) s = 32'(m_pend);
            else if (a == A_STAT)
                s = 32'(m_id) * 16 + 32'(m_rr) * 256
                  + ((m_phase == 1) ? 32'd1 : 32'd0)
                  + ((m_phase == 2) ? 32'd2 : 32'd0);
        end
        return s;
    endfunction

    task automatic model_edge(logic rst, logic wr, logic [31:0] a,
                              logic [31:0] din, logic [3:0] iv,
                              logic ack);
        int       pick;
        bit [3:0] clr;
        bit [3:0] rise;
        if (rst) begin
            m_phase = 0; m_pend = 0; m_mask = 0;
            m_prev = 0; m_id = 0; m_rr = 0;
            m_valid = 1'b1;
            return;
        end
        pick = -1;
        for (int off = 0; off < NSRC; off++) begin
            int j;
            j = (m_rr + off) % NSRC;
            if (pick < 0 && m_pend[j] && m_mask[j]) pick = j;
        end
        clr = 0;
        if (m_phase == 1 && ack) clr[m_id] = 1'b1;
        if (wr && a == A_PEND) clr = clr | din[3:0];
        rise = iv & ~m_prev;
        m_prev = iv;
        m_pend = rise | (m_pend & ~clr);
        if (wr && a == A_MASK) m_mask = din[3:0];
        if (m_phase == 0 && pick >= 0) begin
            m_phase = 1; m_id = pick;
        end else if (m_phase == 1 && ack) begin
            m_phase = 2;
        end else if (m_phase == 2 && wr && a == A_STAT) begin
            m_phase = 0; m_rr = (m_id + 1) % NSRC;
        end
    endtask

    // One clock: drive, check pre-edge outputs, advance model and DUT
    task automatic cyc(vec_t v, bit expl, string tag);
        reset = v.rst; we = v.wr; re = v.rd;
        memAddr = v.addr; dataBusIn = v.din;
        irq = v.irqv; intAck = v.ack;
        #1;
        if (m_valid) begin
            chk({tag, " model intReq"}, 32'(intReq),
                (m_phase == 1) ? 32'd1 : 32'd0);
            chk({tag, " model intId"}, 32'(intId), 32'(m_id));
            chk({tag, " model dout"}, dataBusOut,
                m_read(v.rd, v.wr, v.addr));
        end
        if (expl) begin
            chk({tag, " intReq"}, 32'(intReq), 32'(v.e_req));
            chk({tag, " intId"}, 32'(intId), 32'(v.e_id));
            chk({tag, " dout"}, dataBusOut, v.e_dout);
        end
        model_edge(v.rst, v.wr, v.addr, v.din, v.irqv, v.ack);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [3:0] cur;

        // single-source service, then two simultaneous sources
        tbl.push_back(mk(0,1,0,A_MASK,32'hF,4'h0,0, 0,0,32'h0));
        tbl.push_back(mk(0,0,1,A_MASK,0,4'h4,0,     0,0,32'hF));
        tbl.push_back(mk(0,0,1,A_PEND,0,4'h4,0,     0,0,32'h4));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h4,0,     1,2,32'h21));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h4,1,     1,2,32'h21));
        tbl.push_back(mk(0,0,1,A_PEND,0,4'h4,0,     0,2,32'h0));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h4,0,     0,2,32'h22));
        tbl.push_back(mk(0,1,0,A_STAT,0,4'h4,0,     0,2,32'h0));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h4,0,     0,2,32'h320));
        tbl.push_back(mk(1,0,0,A_NONE,0,4'h0,0,     0,2,32'h0));
        tbl.push_back(mk(0,1,0,A_MASK,32'hF,4'h9,0, 0,0,32'h0));
        tbl.push_back(mk(0,0,1,A_PEND,0,4'h9,0,     0,0,32'h9));
        tbl.push_back(mk(0,0,0,A_NONE,0,4'h9,1,     1,0,32'h0));
        tbl.push_back(mk(0,1,0,A_STAT,0,4'h9,0,     0,0,32'h0));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h9,0,     0,0,32'h100));
        tbl.push_back(mk(0,0,1,A_STAT,0,4'h9,0,     1,3,32'h131));

        reset = 1'b1; we = 0; re = 0; memAddr = 0;
        dataBusIn = 0; irq = 0; intAck = 0;
        cyc(mk(1,0,0,A_NONE,0,0,0,0,0,0), 0, "init");
        cyc(mk(1,0,0,A_NONE,0,0,0,0,0,0), 0, "init");

        for (int r = 0; r < tbl.size(); r++) begin
            cyc(tbl[r], 1, $sformatf("row%0d", r));
        end

        // masked source records edge, unmask releases it
        cyc(mk(1,0,0,A_NONE,0,4'h0,0,0,0,0),     0, "m_a");
        cyc(mk(0,0,0,A_NONE,0,4'h2,0,0,0,0),     1, "m_b");
        cyc(mk(0,0,1,A_PEND,0,4'h2,0,0,0,32'h2), 1, "m_c");
        cyc(mk(0,0,1,A_PEND,0,4'h2,0,0,0,32'h2), 1, "m_d");
        cyc(mk(0,1,0,A_MASK,32'h2,4'h2,0,0,0,0), 1, "m_e");
        cyc(mk(0,0,1,A_MASK,0,4'h2,0,0,0,32'h2), 1, "m_f");
        cyc(mk(0,0,0,A_NONE,0,4'h2,0,1,1,0),     1, "m_g");
        // re-edge while in service waits for EOI
        cyc(mk(0,0,0,A_NONE,0,4'h2,1,1,1,0),      1, "s_h");
        cyc(mk(0,0,0,A_NONE,0,4'h0,0,0,1,0),      1, "s_i");
        cyc(mk(0,0,0,A_NONE,0,4'h2,0,0,1,0),      1, "s_j");
        cyc(mk(0,0,1,A_PEND,0,4'h2,0,0,1,32'h2),  1, "s_k");
        cyc(mk(0,0,1,A_STAT,0,4'h2,0,0,1,32'h12), 1, "s_l");
        cyc(mk(0,1,0,A_STAT,0,4'h2,0,0,1,0),      1, "s_m");
        cyc(mk(0,0,1,A_STAT,0,4'h2,0,0,1,32'h210),1, "s_n");
        cyc(mk(0,0,1,A_STAT,0,4'h2,0,1,1,32'h211),1, "s_o");
        // reset mid-REQ beats a mask write and an ack
        cyc(mk(1,1,0,A_MASK,32'hF,4'h0,1,1,1,0),  1, "r_p");
        cyc(mk(0,0,1,A_STAT,0,4'h0,0,0,0,32'h0),  1, "r_q");
        cyc(mk(0,0,1,A_PEND,0,4'h0,0,0,0,32'h0),  1, "r_r");
        cyc(mk(0,0,1,A_MASK,0,4'h0,0,0,0,32'h0),  1, "r_s");

        // randomized traffic against the model
        cur = 4'h0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) cur = 4'($urandom);
            v.rst  = ($urandom_range(0, 79) == 0);
            v.wr   = ($urandom_range(0, 5) == 0);
            v.rd   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: v.addr = A_MASK;
                1: v.addr = A_PEND;
                2: v.addr = A_STAT;
                default: v.addr = A_NONE;
            endcase
            v.din  = $urandom;
            v.irqv = cur;
            v.ack  = ($urandom_range(0, 3) == 0);
            v.e_req = 0; v.e_id = 0; v.e_dout = 0;
            cyc(v, 0, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
